// File: rtl/multicycle_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl_pkg
// Shared encodings for the multi-cycle control unit and its ALU decoder:
//   state_t      - controller FSM states
//   OP_* / F_*   - opcode and R-type funct field values
//   alu_ctl_t    - ALU_Control operation codes
//   trap_cause_t - sticky trap cause codes
// -----------------------------------------------------------------------------
package multicycle_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        EXEC_R,
        WB_R,
        ADDR,
        MEM_RD,
        WB_MEM,
        MEM_WR,
        BRANCH,
        TRAP
    } state_t;

    localparam logic [5:0] OP_R   = 6'b000001;
    localparam logic [5:0] OP_LW  = 6'b000100;
    localparam logic [5:0] OP_SW  = 6'b000010;
    localparam logic [5:0] OP_BEQ = 6'b000011;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;

    typedef enum logic [3:0] {
        ALU_NOP = 4'b0000,
        ALU_AND = 4'b0001,
        ALU_OR  = 4'b0010,
        ALU_ADD = 4'b0101,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111
    } alu_ctl_t;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'b00,
        CAUSE_ILL_OP  = 2'b01,
        CAUSE_ILL_FN  = 2'b10,
        CAUSE_TIMEOUT = 2'b11
    } trap_cause_t;

endpackage

// File: rtl/multicycle_controlunit_alu_decoder.sv
// -----------------------------------------------------------------------------
// alu_decoder
// Combinational R-type funct to ALU_Control mapping.
// Ports:
//   funct       in  FUNCT_W   funct field from IR
//   alu_ctl     out ALUCTL_W  ALU operation (NOP when funct is illegal)
//   illegal     out 1         funct is not a supported R-type operation
// -----------------------------------------------------------------------------
module alu_decoder
    import multicycle_ctrl_pkg::*;
#(
    parameter int unsigned FUNCT_W  = 6,
    parameter int unsigned ALUCTL_W = 4
) (
    input  logic [FUNCT_W-1:0]  funct,
    output logic [ALUCTL_W-1:0] alu_ctl,
    output logic                illegal
);

    always_comb begin
        alu_ctl = ALUCTL_W'(ALU_NOP);
        illegal = 1'b0;
        case (funct)
            FUNCT_W'(F_ADD): alu_ctl = ALUCTL_W'(ALU_ADD);
            FUNCT_W'(F_SUB): alu_ctl = ALUCTL_W'(ALU_SUB);
            FUNCT_W'(F_AND): alu_ctl = ALUCTL_W'(ALU_AND);
            FUNCT_W'(F_OR):  alu_ctl = ALUCTL_W'(ALU_OR);
            FUNCT_W'(F_SLT): alu_ctl = ALUCTL_W'(ALU_SLT);
            default:         illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_controlunit.sv
// -----------------------------------------------------------------------------
// multicycle_controlunit
// Multi-cycle FSM controller: FETCH -> DECODE -> (EXEC_R/WB_R | ADDR/MEM_RD/
// WB_MEM | ADDR/MEM_WR | BRANCH) -> FETCH, with a req/ready memory handshake,
// a per-access wait timeout and a sticky TRAP state.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   opcode, funct                IR fields
//   mem_ready                    memory completes the current access
//   mem_req, IorD, MemRead,
//   MemWrite                     memory request / address select / strobes
//   IRWrite, PCWrite,
//   PCWriteCond                  IR and PC load enables
//   RegDst, MemToReg, RegWrite   register-file write controls
//   ALUSrcA, ALUSrcB,
//   ALU_Control                  ALU operand selects and operation
//   retire                       one-cycle instruction completion pulse
//   trap, trap_cause             sticky error flag and cause
// -----------------------------------------------------------------------------
module multicycle_controlunit
    import multicycle_ctrl_pkg::*;
#(
    parameter int unsigned OPCODE_W = 6,
    parameter int unsigned FUNCT_W  = 6,
    parameter int unsigned ALUCTL_W = 4,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [FUNCT_W-1:0]  funct,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic                IorD,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                IRWrite,
    output logic                PCWrite,
    output logic                PCWriteCond,
    output logic                RegDst,
    output logic                MemToReg,
    output logic                RegWrite,
    output logic                ALUSrcA,
    output logic [1:0]          ALUSrcB,
    output logic [ALUCTL_W-1:0] ALU_Control,
    output logic                retire,
    output logic                trap,
    output logic [1:0]          trap_cause
);

    // Counter only has to reach TIMEOUT-1.
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] WAIT_LAST =
        (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    state_t             r_state;
    state_t             w_next;
    trap_cause_t        r_cause;
    trap_cause_t        w_next_cause;
    logic [CNT_W-1:0]   r_wait;
    logic               w_waiting;
    logic               w_timeout;
    logic [ALUCTL_W-1:0] w_alu_funct;
    logic               w_funct_illegal;

    alu_decoder #(
        .FUNCT_W  (FUNCT_W),
        .ALUCTL_W (ALUCTL_W)
    ) u_alu_decoder (
        .funct   (funct),
        .alu_ctl (w_alu_funct),
        .illegal (w_funct_illegal)
    );

    assign w_waiting = (r_state == FETCH) || (r_state == MEM_RD) || (r_state == MEM_WR);
    // mem_ready in the final allowed cycle takes priority over the timeout.
    assign w_timeout = (TIMEOUT != 0) && w_waiting && !mem_ready && (r_wait == WAIT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FETCH;
            r_cause <= CAUSE_NONE;
            r_wait  <= '0;
        end else begin
            r_state <= w_next;
            r_cause <= w_next_cause;
            // Count only while stalled in a memory state; any other transition
            // (entry, completion, trap) leaves the counter cleared.
            if (w_waiting && !mem_ready && (w_next == r_state))
                r_wait <= r_wait + CNT_W'(1);
            else
                r_wait <= '0;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_next_cause = r_cause;
        case (r_state)
            FETCH:  if (mem_ready) w_next = DECODE;
            DECODE: begin
                if (opcode == OPCODE_W'(OP_R)) begin
                    if (w_funct_illegal) begin
                        w_next       = TRAP;
                        w_next_cause = CAUSE_ILL_FN;
                    end else begin
                        w_next = EXEC_R;
                    end
                end else if ((opcode == OPCODE_W'(OP_LW)) || (opcode == OPCODE_W'(OP_SW))) begin
                    w_next = ADDR;
                end else if (opcode == OPCODE_W'(OP_BEQ)) begin
                    w_next = BRANCH;
                end else begin
                    w_next       = TRAP;
                    w_next_cause = CAUSE_ILL_OP;
                end
            end
            EXEC_R: w_next = WB_R;
            WB_R:   w_next = FETCH;
            ADDR:   w_next = (opcode == OPCODE_W'(OP_LW)) ? MEM_RD : MEM_WR;
            MEM_RD: if (mem_ready) w_next = WB_MEM;
            WB_MEM: w_next = FETCH;
            MEM_WR: if (mem_ready) w_next = FETCH;
            BRANCH: w_next = FETCH;
            TRAP:   w_next = TRAP;
            default: w_next = FETCH;
        endcase
        if (w_timeout) begin
            w_next       = TRAP;
            w_next_cause = CAUSE_TIMEOUT;
        end
    end

    // Outputs are forced low while rst is high so nothing is issued during reset.
    always_comb begin
        mem_req     = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        RegDst      = 1'b0;
        MemToReg    = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALU_Control = ALUCTL_W'(ALU_NOP);
        retire      = 1'b0;
        trap        = 1'b0;
        trap_cause  = 2'b00;
        if (!rst) begin
            trap_cause = r_cause;
            case (r_state)
                FETCH: begin
                    mem_req = 1'b1;
                    MemRead = 1'b1;
                    if (mem_ready) begin
                        IRWrite     = 1'b1;
                        PCWrite     = 1'b1;
                        ALUSrcB     = 2'b01;
                        ALU_Control = ALUCTL_W'(ALU_ADD);
                    end
                end
                DECODE: begin
                    ALUSrcB     = 2'b10;
                    ALU_Control = ALUCTL_W'(ALU_ADD);
                end
                EXEC_R: begin
                    ALUSrcA     = 1'b1;
                    ALU_Control = w_alu_funct;
                end
                WB_R: begin
                    RegWrite = 1'b1;
                    RegDst   = 1'b1;
                    retire   = 1'b1;
                end
                ADDR: begin
                    ALUSrcA     = 1'b1;
                    ALUSrcB     = 2'b10;
                    ALU_Control = ALUCTL_W'(ALU_ADD);
                end
                MEM_RD: begin
                    mem_req = 1'b1;
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                WB_MEM: begin
                    RegWrite = 1'b1;
                    MemToReg = 1'b1;
                    retire   = 1'b1;
                end
                MEM_WR: begin
                    mem_req  = 1'b1;
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                    retire   = mem_ready;
                end
                BRANCH: begin
                    ALUSrcA     = 1'b1;
                    ALU_Control = ALUCTL_W'(ALU_SUB);
                    PCWriteCond = 1'b1;
                    retire      = 1'b1;
                end
                TRAP: trap = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_controlunit.sv
// -----------------------------------------------------------------------------
// tb_multicycle_controlunit
// Directed checks of the multi-cycle controller. Every cycle the full output
// bundle is compared against a hand-written expected vector.
// Bundle layout (MSB..LSB):
//   mem_req IorD MemRead MemWrite | IRWrite PCWrite PCWriteCond |
//   RegDst MemToReg RegWrite | ALUSrcA | ALUSrcB[1:0] | ALU_Control[3:0] |
//   retire | trap | trap_cause[1:0]
// -----------------------------------------------------------------------------
module tb_multicycle_controlunit;

    logic       clk;
    logic       rst;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       mem_ready;
    logic       mem_req, IorD, MemRead, MemWrite, IRWrite, PCWrite, PCWriteCond;
    logic       RegDst, MemToReg, RegWrite, ALUSrcA, retire, trap;
    logic [1:0] ALUSrcB;
    logic [3:0] ALU_Control;
    logic [1:0] trap_cause;
    logic [20:0] obs;

    int tests_run;
    int tests_failed;

    multicycle_controlunit #(
        .OPCODE_W (6),
        .FUNCT_W  (6),
        .ALUCTL_W (4),
        .TIMEOUT  (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .opcode      (opcode),
        .funct       (funct),
        .mem_ready   (mem_ready),
        .mem_req     (mem_req),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .IRWrite     (IRWrite),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .RegDst      (RegDst),
        .MemToReg    (MemToReg),
        .RegWrite    (RegWrite),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .ALU_Control (ALU_Control),
        .retire      (retire),
        .trap        (trap),
        .trap_cause  (trap_cause)
    );

    assign obs = {mem_req, IorD, MemRead, MemWrite, IRWrite, PCWrite, PCWriteCond,
                  RegDst, MemToReg, RegWrite, ALUSrcA, ALUSrcB, ALU_Control,
                  retire, trap, trap_cause};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [5:0] OPR = 6'b000001, OLW = 6'b000100, OSW = 6'b000010;
    localparam logic [5:0] OBQ = 6'b000011, OBAD = 6'b111111;
    localparam logic [5:0] FADD = 6'b100000;

    localparam logic [20:0] E_ZERO    = '0;
    localparam logic [20:0] E_FETCH_W = {4'b1010, 3'b000, 3'b000, 1'b0, 2'b00, 4'b0000, 1'b0, 1'b0, 2'b00};
    localparam logic [20:0] E_FETCH_R = {4'b1010, 3'b110, 3'b000, 1'b0, 2'b01, 4'b0101, 1'b0, 1'b0, 2'b00};
    localparam logic [20:0] E_DECODE  = {4'b0000, 3'b000, 3'b000, 1'b0, 2'b10, 4'b0101, 1'b0, 1'b0, 2'b00};
    localparam logic [20:0] E_EXADD   = {4'b0000, 3'b000, 3'b000, 1'b1, 2'b00, 4'b0101, 1'b0, 1'b0, 2'b00};
    localparam logic [20:0] E_WB_R    = {4'b0000, 3'b000, 3'b101, 1'b0, 2'b00, 4'b0000, 1'b1, 1'b0, 2'b00};
    localparam logic [20:0] E_ADDR    = {4'b0000, 3'b000, 3'b000, 1'b1, 2'b10, 4'b0101, 1'b0, 1'b0, 2'b00};
    localparam logic [20:0] E_MEMRD   = {4'b1110, 3'b000, 3'b000, 1'b0, 2'b00, 4'b0000, 1'b0, 1'b0, 2'b00};
    localparam logic [20:0] E_WBMEM   = {4'b0000, 3'b000, 3'b011, 1'b0, 2'b00, 4'b0000, 1'b1, 1'b0, 2'b00};
    localparam logic [20:0] E_MEMWR_W = {4'b1101, 3'b000, 3'b000, 1'b0, 2'b00, 4'b0000, 1'b0, 1'b0, 2'b00};
    localparam logic [20:0] E_MEMWR_R = {4'b1101, 3'b000, 3'b000, 1'b0, 2'b00, 4'b0000, 1'b1, 1'b0, 2'b00};
    localparam logic [20:0] E_BRANCH  = {4'b0000, 3'b001, 3'b000, 1'b1, 2'b00, 4'b0110, 1'b1, 1'b0, 2'b00};
    localparam logic [20:0] E_TRAP_OP = {4'b0000, 3'b000, 3'b000, 1'b0, 2'b00, 4'b0000, 1'b0, 1'b1, 2'b01};
    localparam logic [20:0] E_TRAP_FN = {4'b0000, 3'b000, 3'b000, 1'b0, 2'b00, 4'b0000, 1'b0, 1'b1, 2'b10};
    localparam logic [20:0] E_TRAP_TO = {4'b0000, 3'b000, 3'b000, 1'b0, 2'b00, 4'b0000, 1'b0, 1'b1, 2'b11};

    typedef struct packed {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        r;
        logic        rd;
        logic [20:0] exp;
    } step_t;

    function automatic step_t st(input logic [5:0] op, input logic [5:0] fn,
                                 input logic r, input logic rd, input logic [20:0] e);
        step_t s;
        s.op = op; s.fn = fn; s.r = r; s.rd = rd; s.exp = e;
        return s;
    endfunction

    task automatic test_reset();
        step_t s [6];
        s = '{st(OPR, FADD, 1, 1, E_ZERO),    st(OPR, FADD, 1, 1, E_ZERO),
              st(OPR, FADD, 0, 1, E_FETCH_R), st(OPR, FADD, 0, 1, E_DECODE),
              st(OPR, FADD, 0, 1, E_EXADD),   st(OPR, FADD, 0, 1, E_WB_R)};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            opcode = s[i].op; funct = s[i].fn; rst = s[i].r; mem_ready = s[i].rd;
            #1;
            tests_run++;
            if (obs !== s[i].exp) begin
                tests_failed++;
                $display("FAIL reset step %0d: got %b expected %b", i, obs, s[i].exp);
            end
        end
    endtask

    // mem_ready held high in every state: only FETCH may react to it.
    task automatic test_r_type();
        logic [5:0] fn [5];
        logic [3:0] al [5];
        logic [20:0] ex [4];
        fn = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        al = '{4'b0101,   4'b0110,   4'b0001,   4'b0010,   4'b0111};
        for (int k = 0; k < 5; k++) begin
            ex = '{E_FETCH_R, E_DECODE,
                   {4'b0000, 3'b000, 3'b000, 1'b1, 2'b00, al[k], 1'b0, 1'b0, 2'b00},
                   E_WB_R};
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                opcode = OPR; funct = fn[k]; rst = 1'b0; mem_ready = 1'b1;
                #1;
                tests_run++;
                if (obs !== ex[i]) begin
                    tests_failed++;
                    $display("FAIL r_type funct %b step %0d: got %b expected %b", fn[k], i, obs, ex[i]);
                end
            end
        end
    endtask

    task automatic test_lw();
        step_t s [8];
        s = '{st(OLW, 0, 0, 1, E_FETCH_R), st(OLW, 0, 0, 0, E_DECODE),
              st(OLW, 0, 0, 0, E_ADDR),    st(OLW, 0, 0, 0, E_MEMRD),
              st(OLW, 0, 0, 0, E_MEMRD),   st(OLW, 0, 0, 0, E_MEMRD),
              st(OLW, 0, 0, 1, E_MEMRD),   st(OLW, 0, 0, 1, E_WBMEM)};
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            opcode = s[i].op; funct = s[i].fn; rst = s[i].r; mem_ready = s[i].rd;
            #1;
            tests_run++;
            if (obs !== s[i].exp) begin
                tests_failed++;
                $display("FAIL lw step %0d: got %b expected %b", i, obs, s[i].exp);
            end
        end
    endtask

    task automatic test_sw_beq();
        step_t s [10];
        s = '{st(OSW, 0, 0, 1, E_FETCH_R), st(OSW, 0, 0, 0, E_DECODE),
              st(OSW, 0, 0, 0, E_ADDR),    st(OSW, 0, 0, 0, E_MEMWR_W),
              st(OSW, 0, 0, 1, E_MEMWR_R),
              st(OBQ, 0, 0, 0, E_FETCH_W), st(OBQ, 0, 0, 0, E_FETCH_W),
              st(OBQ, 0, 0, 1, E_FETCH_R), st(OBQ, 0, 0, 0, E_DECODE),
              st(OBQ, 0, 0, 0, E_BRANCH)};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            opcode = s[i].op; funct = s[i].fn; rst = s[i].r; mem_ready = s[i].rd;
            #1;
            tests_run++;
            if (obs !== s[i].exp) begin
                tests_failed++;
                $display("FAIL sw_beq step %0d: got %b expected %b", i, obs, s[i].exp);
            end
        end
    endtask

    // Trap must hold through changing opcode/funct/mem_ready until rst.
    task automatic test_illegal();
        step_t s [12];
        s = '{st(OBAD, FADD, 0, 1, E_FETCH_R), st(OBAD, FADD, 0, 0, E_DECODE),
              st(OPR,  FADD, 0, 1, E_TRAP_OP), st(OLW,  FADD, 0, 0, E_TRAP_OP),
              st(OBQ,  FADD, 0, 1, E_TRAP_OP), st(OPR,  FADD, 1, 1, E_ZERO),
              st(OPR, 6'b000111, 0, 1, E_FETCH_R), st(OPR, 6'b000111, 0, 0, E_DECODE),
              st(OPR,  FADD, 0, 1, E_TRAP_FN), st(OSW,  FADD, 0, 1, E_TRAP_FN),
              st(OPR,  FADD, 0, 0, E_TRAP_FN), st(OPR,  FADD, 1, 0, E_ZERO)};
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            opcode = s[i].op; funct = s[i].fn; rst = s[i].r; mem_ready = s[i].rd;
            #1;
            tests_run++;
            if (obs !== s[i].exp) begin
                tests_failed++;
                $display("FAIL illegal step %0d: got %b expected %b", i, obs, s[i].exp);
            end
        end
    endtask

    // TIMEOUT=4: four stalled cycles trap; ready on the fourth wins.
    // Also covers a MEM_RD timeout and reset aborting a pending access.
    task automatic test_timeout();
        step_t s [28];
        s = '{st(OBQ, 0, 0, 0, E_FETCH_W), st(OBQ, 0, 0, 0, E_FETCH_W),
              st(OBQ, 0, 0, 0, E_FETCH_W), st(OBQ, 0, 0, 0, E_FETCH_W),
              st(OBQ, 0, 0, 1, E_TRAP_TO), st(OBQ, 0, 0, 0, E_TRAP_TO),
              st(OBQ, 0, 1, 0, E_ZERO),
              st(OLW, 0, 0, 0, E_FETCH_W), st(OLW, 0, 0, 0, E_FETCH_W),
              st(OLW, 0, 0, 0, E_FETCH_W), st(OLW, 0, 0, 1, E_FETCH_R),
              st(OLW, 0, 0, 0, E_DECODE),  st(OLW, 0, 0, 0, E_ADDR),
              st(OLW, 0, 0, 0, E_MEMRD),   st(OLW, 0, 0, 0, E_MEMRD),
              st(OLW, 0, 0, 0, E_MEMRD),   st(OLW, 0, 0, 0, E_MEMRD),
              st(OLW, 0, 0, 1, E_TRAP_TO), st(OLW, 0, 1, 0, E_ZERO),
              st(OLW, 0, 0, 1, E_FETCH_R), st(OLW, 0, 0, 0, E_DECODE),
              st(OLW, 0, 0, 0, E_ADDR),    st(OLW, 0, 0, 0, E_MEMRD),
              st(OLW, 0, 1, 0, E_ZERO),
              st(OBQ, 0, 0, 1, E_FETCH_R), st(OBQ, 0, 0, 0, E_DECODE),
              st(OBQ, 0, 0, 0, E_BRANCH),  st(OPR, FADD, 0, 1, E_FETCH_R)};
        for (int i = 0; i < 28; i++) begin
            @(negedge clk);
            opcode = s[i].op; funct = s[i].fn; rst = s[i].r; mem_ready = s[i].rd;
            #1;
            tests_run++;
            if (obs !== s[i].exp) begin
                tests_failed++;
                $display("FAIL timeout step %0d: got %b expected %b", i, obs, s[i].exp);
            end
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        opcode       = '0;
        funct        = '0;
        mem_ready    = 1'b0;
        test_reset();
        test_r_type();
        test_lw();
        test_sw_beq();
        test_illegal();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
